// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
//   Receive-side checker for the TinyVGA PMOD stream. Decodes HSYNC/VSYNC from a
//   registered copy of vga_in, measures line period and lines per frame, flags
//   timing errors (sticky), asserts lock after two consecutive good frames and
//   optionally signs each frame's active pixels.
//   Optional feature macro: VGA_MON_CRC_EN
//     defined   -> CRC-16-CCITT (poly 0x1021, seed 0xFFFF) over active pixels
//     undefined -> no CRC logic, frame_crc tied to zero
module vga_sync_monitor #(
    parameter int H_TOTAL  = 800,
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 480,
    parameter bit SYNC_NEG = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_in,
    input  logic        clear,
    output logic        locked,
    output logic        frame_done,
    output logic [11:0] h_period,
    output logic [10:0] v_lines,
    output logic [15:0] frame_crc,
    output logic [7:0]  frame_count,
    output logic        err_h,
    output logic        err_v
);

    localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
    localparam logic [11:0] TIMEOUT_W = 12'(2 * H_TOTAL);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);

    // Registered input sample and previous sync levels for edge detection
    logic [7:0]  vga_r;
    logic        hs_prev_r;
    logic        vs_prev_r;

    // Counters and measurement state
    logic [11:0] h_cnt_r;
    logic [10:0] v_cnt_r;
    logic        seen_hs_r;
    logic        seen_vs_r;
    logic        good_run_r;
    logic        h_err_frame_r;

    // Output registers
    logic        locked_r;
    logic        frame_done_r;
    logic [11:0] h_period_r;
    logic [10:0] v_lines_r;
    logic [7:0]  frame_count_r;
    logic        err_h_r;
    logic        err_v_r;

    // Decoded events
    logic        hs_start_s;
    logic        vs_start_s;
    logic [11:0] h_len_s;
    logic        h_mismatch_s;
    logic        timeout_s;
    logic        h_evt_s;
    logic        frame_s;
    logic        frame_good_s;

    // Input register plus one-deep history of the two sync pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r     <= 8'h00;
            hs_prev_r <= 1'b0;
            vs_prev_r <= 1'b0;
        end else begin
            vga_r     <= vga_in;
            hs_prev_r <= vga_r[7];
            vs_prev_r <= vga_r[3];
        end
    end

    // Sync-start edge detection and per-cycle timing events
    always_comb begin
        hs_start_s   = 1'b0;
        vs_start_s   = 1'b0;
        if (SYNC_NEG) begin
            hs_start_s = hs_prev_r & ~vga_r[7];
            vs_start_s = vs_prev_r & ~vga_r[3];
        end else begin
            hs_start_s = ~hs_prev_r & vga_r[7];
            vs_start_s = ~vs_prev_r & vga_r[3];
        end
        h_len_s      = h_cnt_r + 12'd1;
        h_mismatch_s = hs_start_s & seen_hs_r & (h_len_s != H_TOTAL_W);
        // h_cnt passes the timeout value only once per stall, so this fires once
        timeout_s    = (h_cnt_r == TIMEOUT_W);
        h_evt_s      = h_mismatch_s | timeout_s;
        frame_s      = vs_start_s & seen_vs_r;
        // a line error in the closing cycle still belongs to the frame just ended
        frame_good_s = (v_cnt_r == V_TOTAL_W) & ~h_err_frame_r & ~h_evt_s;
    end

    // Horizontal and vertical position counters, both saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r <= 12'd0;
            v_cnt_r <= 11'd0;
        end else begin
            if (hs_start_s) begin
                h_cnt_r <= 12'd0;
            end else if (h_cnt_r != 12'hFFF) begin
                h_cnt_r <= h_cnt_r + 12'd1;
            end else begin
                h_cnt_r <= h_cnt_r;
            end
            if (vs_start_s) begin
                v_cnt_r <= hs_start_s ? 11'd1 : 11'd0;
            end else if (hs_start_s && (v_cnt_r != 11'h7FF)) begin
                v_cnt_r <= v_cnt_r + 11'd1;
            end else begin
                v_cnt_r <= v_cnt_r;
            end
        end
    end

    // Line period measurement and sticky horizontal error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_hs_r  <= 1'b0;
            h_period_r <= 12'd0;
            err_h_r    <= 1'b0;
        end else if (clear) begin
            seen_hs_r  <= 1'b0;
            err_h_r    <= 1'b0;
        end else begin
            if (hs_start_s) begin
                seen_hs_r <= 1'b1;
                if (seen_hs_r) begin
                    h_period_r <= h_len_s;
                end
            end
            if (h_evt_s) begin
                err_h_r <= 1'b1;
            end
        end
    end

    // Frame measurement, lock tracking and sticky vertical error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_vs_r     <= 1'b0;
            good_run_r    <= 1'b0;
            h_err_frame_r <= 1'b0;
            locked_r      <= 1'b0;
            frame_done_r  <= 1'b0;
            v_lines_r     <= 11'd0;
            frame_count_r <= 8'd0;
            err_v_r       <= 1'b0;
        end else if (clear) begin
            seen_vs_r     <= 1'b0;
            good_run_r    <= 1'b0;
            h_err_frame_r <= 1'b0;
            locked_r      <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_count_r <= 8'd0;
            err_v_r       <= 1'b0;
        end else begin
            frame_done_r <= frame_s;
            if (vs_start_s) begin
                seen_vs_r     <= 1'b1;
                h_err_frame_r <= 1'b0;
            end else if (h_evt_s) begin
                h_err_frame_r <= 1'b1;
            end
            if (frame_s) begin
                v_lines_r     <= v_cnt_r;
                frame_count_r <= frame_count_r + 8'd1;
                if (v_cnt_r != V_TOTAL_W) begin
                    err_v_r <= 1'b1;
                end
                if (frame_good_s) begin
                    good_run_r <= 1'b1;
                    if (good_run_r) begin
                        locked_r <= 1'b1;
                    end
                end else begin
                    good_run_r <= 1'b0;
                    locked_r   <= 1'b0;
                end
            end
            // a stalled line drops lock at once, not at the next frame edge
            if (timeout_s) begin
                locked_r <= 1'b0;
            end
        end
    end

`ifdef VGA_MON_CRC_EN
    localparam logic [11:0] H_START_W = 12'(H_START);
    localparam logic [11:0] H_END_W   = 12'(H_START + H_ACTIVE);
    localparam logic [10:0] V_START_W = 11'(V_START);
    localparam logic [10:0] V_END_W   = 11'(V_START + V_ACTIVE);

    logic [15:0] crc_r;
    logic [15:0] frame_crc_r;
    logic [5:0]  px_s;
    logic        active_s;

    // Shift one 6-bit pixel MSB first through CRC-16-CCITT
    function automatic logic [15:0] crc16_px(input logic [15:0] crc_in, input logic [5:0] px);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 5; i >= 0; i--) begin
            fb = c[15] ^ px[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // Pixel reorder to {R1,R0,G1,G0,B1,B0} and active-window decode
    always_comb begin
        px_s     = {vga_r[0], vga_r[4], vga_r[1], vga_r[5], vga_r[2], vga_r[6]};
        active_s = (h_cnt_r >= H_START_W) && (h_cnt_r < H_END_W) &&
                   (v_cnt_r >= V_START_W) && (v_cnt_r < V_END_W);
    end

    // Running CRC, reseeded on every VSYNC start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r <= 16'hFFFF;
        end else if (vs_start_s) begin
            crc_r <= 16'hFFFF;
        end else if (active_s) begin
            crc_r <= crc16_px(crc_r, px_s);
        end else begin
            crc_r <= crc_r;
        end
    end

    // Capture the finished frame's CRC; clear suppresses the frame edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_crc_r <= 16'h0000;
        end else if (frame_s && !clear) begin
            frame_crc_r <= crc_r;
        end else begin
            frame_crc_r <= frame_crc_r;
        end
    end

    assign frame_crc = frame_crc_r;
`else
    assign frame_crc = 16'h0000;
`endif

    assign locked      = locked_r;
    assign frame_done  = frame_done_r;
    assign h_period    = h_period_r;
    assign v_lines     = v_lines_r;
    assign frame_count = frame_count_r;
    assign err_h       = err_h_r;
    assign err_v       = err_v_r;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor
//   Directed bench on a scaled-down raster (40 clocks x 10 lines). Stimulus pushes
//   hand-computed per-frame expectations into a queue; a monitor pops and compares
//   on every frame_done pulse. Point checks cover reset, timeout, clear and rst_n.
module tb_vga_sync_monitor;

    localparam int H  = 40;
    localparam int HS = 8;
    localparam int HA = 24;
    localparam int V  = 10;
    localparam int VS = 2;
    localparam int VA = 6;
    localparam int NPIX = HA * VA;

    // frame kinds
    localparam int K_GOOD   = 0;
    localparam int K_SHORTL = 1;
    localparam int K_SHORTF = 2;
    localparam int K_STALL  = 3;
    localparam int K_CLEAR  = 4;
    localparam int K_RESET  = 5;

    // per-line actions
    localparam int M_NONE  = 0;
    localparam int M_TMO   = 1;
    localparam int M_CLR   = 2;
    localparam int M_CLR_N = 3;
    localparam int M_RST   = 4;
    localparam int M_RST_N = 5;
    localparam int M_RST_M = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  vga_in;
    logic        clear;
    logic        locked;
    logic        frame_done;
    logic [11:0] h_period;
    logic [10:0] v_lines;
    logic [15:0] frame_crc;
    logic [7:0]  frame_count;
    logic        err_h;
    logic        err_v;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          vl;
        int          fc;
        logic        lk;
        logic        eh;
        logic        ev;
        int          hp;
        logic [15:0] crc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_m;

    logic [15:0] crc_blk;
    logic [15:0] crc_3f;

    vga_sync_monitor #(
        .H_TOTAL(H), .H_START(HS), .H_ACTIVE(HA),
        .V_TOTAL(V), .V_START(VS), .V_ACTIVE(VA), .SYNC_NEG(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vga_in(vga_in), .clear(clear),
        .locked(locked), .frame_done(frame_done), .h_period(h_period),
        .v_lines(v_lines), .frame_crc(frame_crc), .frame_count(frame_count),
        .err_h(err_h), .err_v(err_v)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_crc(input logic [5:0] px, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 5; b >= 0; b--) begin
                if (c[15] ^ px[b]) c = {c[14:0], 1'b0} ^ 16'h1021;
                else               c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    // rgb = {R1,R0,G1,G0,B1,B0}
    function automatic logic [7:0] mkvga(input logic hs, input logic vs, input logic [5:0] rgb);
        return {hs, rgb[0], rgb[2], rgb[4], vs, rgb[1], rgb[3], rgb[5]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int vl, input int fc, input logic lk, input logic eh,
                            input logic ev, input int hp, input logic [15:0] crc);
        exp_t e;
        e.vl = vl; e.fc = fc; e.lk = lk; e.eh = eh; e.ev = ev; e.hp = hp; e.crc = crc;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every frame_done pulse against the oldest expectation
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL frame_done: unexpected pulse at %0t, expected none", $time);
            end else begin
                e_m = exp_q.pop_front();
                check("v_lines",     32'(v_lines),     32'(e_m.vl));
                check("frame_count", 32'(frame_count), 32'(e_m.fc));
                check("locked",      32'(locked),      32'(e_m.lk));
                check("err_h",       32'(err_h),       32'(e_m.eh));
                check("err_v",       32'(err_v),       32'(e_m.ev));
                check("h_period",    32'(h_period),    32'(e_m.hp));
                check("frame_crc",   32'(frame_crc),   32'(e_m.crc));
            end
        end
    end

    task automatic drive_line(input int len, input logic vs_low, input logic [5:0] rgb, input int mode);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            vga_in = mkvga((i < 4) ? 1'b0 : 1'b1, vs_low ? 1'b0 : 1'b1, rgb);
            case (mode)
                M_TMO: begin
                    if (i == 80) check("tmo_not_early_locked", 32'(locked), 32'd1);
                    if (i == 90) check("tmo_locked", 32'(locked), 32'd0);
                    if (i == 90) check("tmo_err_h", 32'(err_h), 32'd1);
                end
                M_CLR: begin
                    if (i == 1) clear = 1'b1;
                    if (i == 2) clear = 1'b0;
                    if (i == 3) begin
                        check("clr_err_h",       32'(err_h),       32'd0);
                        check("clr_err_v",       32'(err_v),       32'd0);
                        check("clr_locked",      32'(locked),      32'd0);
                        check("clr_frame_count", 32'(frame_count), 32'd0);
                        check("clr_keep_vlines", 32'(v_lines),     32'd10);
                        check("clr_keep_crc",    32'(frame_crc),   32'(crc_3f));
                    end
                end
                M_CLR_N: begin
                    if (i == 5) check("clr_first_edge_hp", 32'(h_period), 32'd40);
                    if (i == 5) check("clr_first_edge_err_h", 32'(err_h), 32'd0);
                end
                M_RST: begin
                    if (i == 20) rst_n = 1'b0;
                    if (i == 21) begin
                        check("rst_locked",      32'(locked),      32'd0);
                        check("rst_h_period",    32'(h_period),    32'd0);
                        check("rst_v_lines",     32'(v_lines),     32'd0);
                        check("rst_frame_count", 32'(frame_count), 32'd0);
                        check("rst_err",         32'({err_h, err_v}), 32'd0);
                        check("rst_frame_crc",   32'(frame_crc),   32'd0);
                    end
                    if (i == 23) rst_n = 1'b1;
                end
                M_RST_N: begin
                    if (i == 5) check("rst_first_edge_hp", 32'(h_period), 32'd0);
                end
                M_RST_M: begin
                    if (i == 5) check("rst_second_edge_hp", 32'(h_period), 32'd40);
                end
                default: begin
                end
            endcase
        end
    endtask

    task automatic send_frame(input int kind, input logic [5:0] rgb);
        int nl;
        int len;
        int mode;
        nl = (kind == K_SHORTF) ? V - 1 : V;
        for (int l = 0; l < nl; l++) begin
            len  = H;
            mode = M_NONE;
            case (kind)
                K_SHORTL: if (l == V - 1) len = H - 1;
                K_STALL:  if (l == 3) begin len = 170; mode = M_TMO; end
                K_CLEAR: begin
                    if (l == 3) begin len = 33; mode = M_CLR; end
                    if (l == 4) mode = M_CLR_N;
                end
                K_RESET: begin
                    if (l == 4) mode = M_RST;
                    if (l == 5) mode = M_RST_N;
                    if (l == 6) mode = M_RST_M;
                end
                default: begin
                end
            endcase
            drive_line(len, (l < 2) ? 1'b1 : 1'b0, rgb, mode);
        end
    endtask

    initial begin
`ifdef VGA_MON_CRC_EN
        crc_blk = ref_crc(6'h00, NPIX);
        crc_3f  = ref_crc(6'h3F, NPIX);
`else
        crc_blk = 16'h0000;
        crc_3f  = 16'h0000;
`endif
        rst_n  = 1'b0;
        clear  = 1'b0;
        vga_in = mkvga(1'b1, 1'b1, 6'h00);
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({locked, frame_done, err_h, err_v}), 32'd0);
        check("reset_counts",  32'({h_period, v_lines, frame_count}), 32'd0);
        check("reset_crc",     32'(frame_crc), 32'd0);
        rst_n = 1'b1;

        // ideal sync: lock after the third VSYNC edge
        send_frame(K_GOOD, 6'h00);
        push_exp(10, 1, 1'b0, 1'b0, 1'b0, 40, crc_blk);
        send_frame(K_GOOD, 6'h00);
        push_exp(10, 2, 1'b1, 1'b0, 1'b0, 40, crc_blk);
        send_frame(K_GOOD, 6'h00);

        // one 39-clock line while locked, then relock
        push_exp(10, 3, 1'b1, 1'b0, 1'b0, 40, crc_blk);
        send_frame(K_SHORTL, 6'h00);
        push_exp(10, 4, 1'b0, 1'b1, 1'b0, 39, crc_blk);
        send_frame(K_GOOD, 6'h00);
        push_exp(10, 5, 1'b0, 1'b1, 1'b0, 40, crc_blk);
        send_frame(K_GOOD, 6'h00);
        push_exp(10, 6, 1'b1, 1'b1, 1'b0, 40, crc_blk);
        send_frame(K_GOOD, 6'h00);

        // 9-line frame
        push_exp(10, 7, 1'b1, 1'b1, 1'b0, 40, crc_blk);
        send_frame(K_SHORTF, 6'h00);
        push_exp(9, 8, 1'b0, 1'b1, 1'b1, 40, crc_blk);
        send_frame(K_GOOD, 6'h00);
        push_exp(10, 9, 1'b0, 1'b1, 1'b1, 40, crc_blk);
        send_frame(K_GOOD, 6'h00);
        push_exp(10, 10, 1'b1, 1'b1, 1'b1, 40, crc_blk);
        send_frame(K_GOOD, 6'h00);

        // HSYNC stall while locked
        push_exp(10, 11, 1'b1, 1'b1, 1'b1, 40, crc_blk);
        send_frame(K_STALL, 6'h00);

        // all-ones pixel frame
        push_exp(10, 12, 1'b0, 1'b1, 1'b1, 40, crc_blk);
        send_frame(K_GOOD, 6'h3F);

        // clear coincident with an HSYNC edge
        push_exp(10, 13, 1'b0, 1'b1, 1'b1, 40, crc_3f);
        send_frame(K_CLEAR, 6'h00);
        send_frame(K_GOOD, 6'h00);

        // rst_n pulse mid-frame
        push_exp(10, 1, 1'b0, 1'b0, 1'b0, 40, crc_blk);
        send_frame(K_RESET, 6'h00);
        send_frame(K_GOOD, 6'h00);
        push_exp(10, 1, 1'b0, 1'b0, 1'b0, 40, crc_blk);
        send_frame(K_GOOD, 6'h00);

        drive_line(H, 1'b0, 6'h00, M_NONE);
        repeat (5) @(negedge clk);
        check("pending_frames", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
